// File: rtl/gecko_tohost_monitor_pkg.sv
// Shared types and exit-code constants for the tohost/console monitor.
package gecko_tohost_monitor_pkg;

    typedef enum logic [1:0] {
        GECKO_RUNNING  = 2'd0,
        GECKO_FINISHED = 2'd1,
        GECKO_FAULTED  = 2'd2
    } gecko_tohost_state_t;

    localparam logic [30:0] GECKO_EXIT_CORE_FAULT = 31'h7FFFFFFF;
    localparam logic [30:0] GECKO_EXIT_WATCHDOG   = 31'h7FFFFFFE;

    // A tohost word with bit 0 set and zero payload means a clean exit.
    function automatic logic gecko_exit_is_clean(input logic [31:0] word);
        return word[31:1] == 31'd0;
    endfunction

endpackage

// File: rtl/gecko_tohost_monitor_if.sv
// Snooped data-memory command stream plus the console byte handshake.
interface gecko_tohost_monitor_if #(
    parameter int ADDR_SPACE_WIDTH = 12
);
    logic                        mem_valid;
    logic                        mem_ready;
    logic [3:0]                  mem_write_enable;
    logic [ADDR_SPACE_WIDTH-1:0] mem_addr;
    logic [31:0]                 mem_data;
    logic                        console_valid;
    logic                        console_ready;
    logic [7:0]                  console_data;

    modport master (
        output mem_valid, mem_ready, mem_write_enable, mem_addr, mem_data,
        output console_ready,
        input  console_valid, console_data
    );

    modport slave (
        input  mem_valid, mem_ready, mem_write_enable, mem_addr, mem_data,
        input  console_ready,
        output console_valid, console_data
    );
endinterface

// File: rtl/gecko_tohost_monitor_console_fifo.sv
// Console byte FIFO: registered head output, combinational full flag.
module gecko_console_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head_q;
    logic              pop, do_push;

    assign full    = count == CW'(DEPTH);
    assign valid   = count != '0;
    assign data    = head_q;
    assign pop     = valid && ready;
    assign do_push = push && (!full || pop);
    assign rd_nxt  = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // The incoming byte becomes the head when it lands where the read pointer will be.
            if (do_push && wr_ptr == rd_nxt) head_q <= push_data;
            else if (pop)                    head_q <= mem[rd_nxt];
        end
    end
endmodule

// File: rtl/gecko_tohost_monitor.sv
// tohost/console snoop monitor producing sticky finished/faulted flags.
// Optional watchdog compiled in with GECKO_TOHOST_WATCHDOG_EN.
module gecko_tohost_monitor
    import gecko_tohost_monitor_pkg::*;
#(
    parameter int                          ADDR_SPACE_WIDTH = 12,
    parameter logic [ADDR_SPACE_WIDTH-1:0] TOHOST_ADDR      = 'hFFF,
    parameter logic [ADDR_SPACE_WIDTH-1:0] CONSOLE_ADDR     = 'hFFE,
    parameter int                          CONSOLE_DEPTH    = 8,
    parameter int unsigned                 WATCHDOG_CYCLES  = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    gecko_tohost_monitor_if.slave   bus,
    input  logic                    core_fault,
    output logic                    console_dropped,
    output logic                    finished_flag,
    output logic                    faulted_flag,
    output logic [30:0]             exit_code
);
    gecko_tohost_state_t state, state_nxt;
    logic [30:0]         exit_nxt;
    logic                xfer, acc, tohost_hit, con_req, fifo_full, pop, push_ok;

    assign xfer       = bus.mem_valid && bus.mem_ready;
    assign acc        = xfer && (bus.mem_write_enable != 4'd0);
    assign tohost_hit = acc && bus.mem_addr == TOHOST_ADDR && bus.mem_data[0];
    assign con_req    = acc && bus.mem_addr == CONSOLE_ADDR && bus.mem_write_enable[0]
                        && state == GECKO_RUNNING;
    assign pop        = bus.console_valid && bus.console_ready;
    assign push_ok    = con_req && (!fifo_full || pop);

`ifdef GECKO_TOHOST_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        wd_expire;

    assign wd_expire = !xfer && wd_cnt == 32'(WATCHDOG_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst)                        wd_cnt <= '0;
        else if (state == GECKO_RUNNING) wd_cnt <= xfer ? 32'd0 : wd_cnt + 32'd1;
    end
`endif

    always_comb begin
        state_nxt = state;
        exit_nxt  = exit_code;
        if (state == GECKO_RUNNING) begin
            if (core_fault) begin
                state_nxt = GECKO_FAULTED;
                exit_nxt  = GECKO_EXIT_CORE_FAULT;
            end else if (tohost_hit) begin
                state_nxt = gecko_exit_is_clean(bus.mem_data) ? GECKO_FINISHED : GECKO_FAULTED;
                exit_nxt  = bus.mem_data[31:1];
            end
`ifdef GECKO_TOHOST_WATCHDOG_EN
            else if (wd_expire) begin
                state_nxt = GECKO_FAULTED;
                exit_nxt  = GECKO_EXIT_WATCHDOG;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= GECKO_RUNNING;
            exit_code       <= '0;
            console_dropped <= 1'b0;
        end else begin
            state     <= state_nxt;
            exit_code <= exit_nxt;
            if (con_req && !push_ok) console_dropped <= 1'b1;
        end
    end

    assign finished_flag = state == GECKO_FINISHED;
    assign faulted_flag  = state == GECKO_FAULTED;

    gecko_console_fifo #(
        .DATA_W (8),
        .DEPTH  (CONSOLE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (bus.mem_data[7:0]),
        .full      (fifo_full),
        .valid     (bus.console_valid),
        .ready     (bus.console_ready),
        .data      (bus.console_data)
    );
endmodule

// File: tb/tb_gecko_tohost_monitor.sv
// Directed bench for gecko_tohost_monitor with a queue-based reference model.
module tb_gecko_tohost_monitor;
    localparam logic [11:0] TOHOST  = 12'hFFF;
    localparam logic [11:0] CONSOLE = 12'hFFE;
    localparam int          DEPTH   = 8;
`ifdef GECKO_TOHOST_WATCHDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 1000000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_fault;
    logic        console_dropped, finished_flag, faulted_flag;
    logic [30:0] exit_code;

    gecko_tohost_monitor_if #(.ADDR_SPACE_WIDTH(12)) bus();

    gecko_tohost_monitor #(
        .ADDR_SPACE_WIDTH (12),
        .TOHOST_ADDR      (TOHOST),
        .CONSOLE_ADDR     (CONSOLE),
        .CONSOLE_DEPTH    (DEPTH),
        .WATCHDOG_CYCLES  (WD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .core_fault      (core_fault),
        .console_dropped (console_dropped),
        .finished_flag   (finished_flag),
        .faulted_flag    (faulted_flag),
        .exit_code       (exit_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state 0=running, 1=finished, 2=faulted; console as a byte queue.
    logic [7:0]  mq[$];
    int          m_state = 0;
    logic [30:0] m_code = '0;
    bit          m_drop = 1'b0;
    int          m_idle = 0;

    always @(posedge clk) begin : model
        bit xfer, acc, pop;
        int pre;
        if (!rst) begin
            mq.delete();
            m_state = 0; m_code = '0; m_drop = 1'b0; m_idle = 0;
        end else begin
            pre  = m_state;
            xfer = bus.mem_valid && bus.mem_ready;
            acc  = xfer && bus.mem_write_enable != 4'd0;
            pop  = mq.size() != 0 && bus.console_ready;
            if (pre == 0) begin
                if (core_fault) begin
                    m_state = 2; m_code = 31'h7FFFFFFF;
                end else if (acc && bus.mem_addr == TOHOST && bus.mem_data[0]) begin
                    m_state = (bus.mem_data[31:1] == 0) ? 1 : 2;
                    m_code  = bus.mem_data[31:1];
                end
`ifdef GECKO_TOHOST_WATCHDOG_EN
                else if (!xfer && m_idle == WD - 1) begin
                    m_state = 2; m_code = 31'h7FFFFFFE;
                end
`endif
                m_idle = xfer ? 0 : m_idle + 1;
            end
            if (pop) void'(mq.pop_front());
            if (pre == 0 && acc && bus.mem_addr == CONSOLE && bus.mem_write_enable[0]) begin
                if (mq.size() < DEPTH) mq.push_back(bus.mem_data[7:0]);
                else                   m_drop = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.console_valid", bus.console_valid, (mq.size() != 0));
            if (mq.size() != 0) chk("model.console_data", bus.console_data, mq[0]);
            chk("model.dropped", console_dropped, m_drop);
            chk("model.finished", finished_flag, m_state == 1);
            chk("model.faulted", faulted_flag, m_state == 2);
            chk("model.exit_code", exit_code, m_code);
        end
    end

    task automatic wrx(input logic [11:0] a, input logic [31:0] d, input logic [3:0] we, input logic rdy);
        bus.mem_valid = 1'b1; bus.mem_ready = rdy; bus.mem_write_enable = we;
        bus.mem_addr = a; bus.mem_data = d;
        @(negedge clk);
        bus.mem_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_write_enable = 4'd0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] we);
        wrx(a, d, we, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [7:0] got [16];
    int         n_got;

    task automatic drain(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if (bus.console_valid && n_got < 16) begin
                got[n_got] = bus.console_data;
                n_got++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        string s;
        rst = 1'b0; core_fault = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_write_enable = 4'd0;
        bus.mem_addr = '0; bus.mem_data = '0; bus.console_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst.console_valid", bus.console_valid, 0);
        chk("rst.console_data", bus.console_data, 0);
        chk("rst.flags", {console_dropped, finished_flag, faulted_flag}, 0);
        chk("rst.exit_code", exit_code, 0);
        rst = 1'b1;

        // Ignored tohost writes: lsb clear, and unaccepted.
        wr(TOHOST, 32'h6, 4'hF);
        wrx(TOHOST, 32'h7, 4'hF, 1'b0);
        chk("ignored.flags", {finished_flag, faulted_flag}, 0);
        wr(TOHOST, 32'h1, 4'hF);
        chk("finish.finished", finished_flag, 1);
        chk("finish.exit", exit_code, 0);
        wr(TOHOST, 32'h7, 4'hF);
        chk("finish.sticky", {finished_flag, faulted_flag}, 2'b10);
        chk("finish.exit_kept", exit_code, 0);

        do_reset();
        wr(TOHOST, 32'h7, 4'hF);
        chk("fault.flags", {finished_flag, faulted_flag}, 2'b01);
        chk("fault.exit", exit_code, 3);

        do_reset();
        core_fault = 1'b1;
        wr(TOHOST, 32'h1, 4'hF);
        core_fault = 1'b0;
        chk("corefault.flags", {finished_flag, faulted_flag}, 2'b01);
        chk("corefault.exit", exit_code, 31'h7FFFFFFF);

        // Overflow: ten bytes into eight entries.
        do_reset();
        wr(CONSOLE, 32'h58, 4'h2);
        chk("mask.no_push", bus.console_valid, 0);
        s = "HELLOWORLD";
        for (int i = 0; i < 10; i++) wr(CONSOLE, {24'h0, s[i]}, 4'h1);
        chk("ovf.dropped", console_dropped, 1);
        chk("ovf.head", bus.console_data, 8'h48);
        bus.console_ready = 1'b1;
        n_got = 0;
        drain(12);
        bus.console_ready = 1'b0;
        chk("ovf.count", n_got, 8);
        s = "HELLOWOR";
        for (int i = 0; i < 8; i++) chk("ovf.byte", got[i], s[i]);
        chk("ovf.empty", bus.console_valid, 0);

        // Push into a full FIFO while it pops.
        do_reset();
        s = "abcdefgh";
        for (int i = 0; i < 8; i++) wr(CONSOLE, {24'h0, s[i]}, 4'h1);
        bus.console_ready = 1'b1;
        n_got = 0;
        got[0] = bus.console_data;
        n_got = 1;
        wr(CONSOLE, 32'h5A, 4'h1);
        drain(12);
        bus.console_ready = 1'b0;
        chk("fullpop.count", n_got, 9);
        chk("fullpop.first", got[0], 8'h61);
        chk("fullpop.last", got[8], 8'h5A);
        chk("fullpop.no_drop", console_dropped, 0);

        // Reset in the middle of a stream with a terminal flag set.
        do_reset();
        for (int i = 0; i < 3; i++) wr(CONSOLE, 32'h30 + i, 4'h1);
        wr(TOHOST, 32'h1, 4'hF);
        wr(CONSOLE, 32'h51, 4'h1);
        chk("mid.finished", finished_flag, 1);
        chk("mid.valid", bus.console_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.rst_valid", bus.console_valid, 0);
        chk("mid.rst_flags", {console_dropped, finished_flag, faulted_flag}, 0);
        chk("mid.rst_exit", exit_code, 0);
        rst = 1'b1;

`ifdef GECKO_TOHOST_WATCHDOG_EN
        do_reset();
        repeat (15) @(negedge clk);
        chk("wd.not_yet", faulted_flag, 0);
        @(negedge clk);
        chk("wd.fault", faulted_flag, 1);
        chk("wd.exit", exit_code, 31'h7FFFFFFE);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            repeat (9) @(negedge clk);
            wr(12'h010, 32'h0, 4'h0);
        end
        chk("wd.kept_alive", faulted_flag, 0);
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
